// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup / EX-update bus of the branch target buffer, plus its statistics outputs.
interface branch_target_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  i_lookup_valid;
    logic [ADDR_WIDTH-1:0] i_lookup_pc;
    logic                  o_hit;
    logic                  o_predict_taken;
    logic [ADDR_WIDTH-1:0] o_target;
    logic                  i_upd_valid;
    logic [ADDR_WIDTH-1:0] i_upd_pc;
    logic [ADDR_WIDTH-1:0] i_upd_target;
    logic                  i_upd_taken;
    logic                  i_upd_is_jump;
    logic                  i_flush;
    logic [CNT_WIDTH-1:0]  o_lookup_count;
    logic [CNT_WIDTH-1:0]  o_hit_count;

    modport master (
        output i_lookup_valid, i_lookup_pc, i_upd_valid, i_upd_pc, i_upd_target,
               i_upd_taken, i_upd_is_jump, i_flush,
        input  o_hit, o_predict_taken, o_target, o_lookup_count, o_hit_count
    );

    modport slave (
        input  i_lookup_valid, i_lookup_pc, i_upd_valid, i_upd_pc, i_upd_target,
               i_upd_taken, i_upd_is_jump, i_flush,
        output o_hit, o_predict_taken, o_target, o_lookup_count, o_hit_count
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-latency lookup from registered entries, 2-bit counter
// direction prediction, allocate-on-taken-miss, flush, saturating hit statistics.
module branch_target_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_target_buffer_if.slave  bus
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [ADDR_WIDTH-1:0] target;
        logic                  is_jump;
        logic [1:0]            ctr;
    } entry_t;

    entry_t               ent_q [ENTRIES];
    entry_t               lk_ent, upd_ent, wr_ent_d;
    logic                 wr_en, lk_hit, upd_hit;
    logic [IDX-1:0]       lk_idx, upd_idx;
    logic [TAG_W-1:0]     lk_tag, upd_tag;
    logic [CNT_WIDTH-1:0] lookup_cnt_q, lookup_cnt_d, hit_cnt_q, hit_cnt_d;
    logic                 unused_pc_lsbs;

    assign lk_idx  = bus.i_lookup_pc[IDX+1:2];
    assign lk_tag  = bus.i_lookup_pc[ADDR_WIDTH-1:IDX+2];
    assign upd_idx = bus.i_upd_pc[IDX+1:2];
    assign upd_tag = bus.i_upd_pc[ADDR_WIDTH-1:IDX+2];
    assign unused_pc_lsbs = ^{bus.i_lookup_pc[1:0], bus.i_upd_pc[1:0]};

    // Lookup reads pre-update state, so a same-cycle update to this index shows up next cycle
    assign lk_ent              = ent_q[lk_idx];
    assign lk_hit              = bus.i_lookup_valid & lk_ent.valid & (lk_ent.tag == lk_tag);
    assign bus.o_hit           = lk_hit;
    assign bus.o_predict_taken = lk_hit & (lk_ent.is_jump | lk_ent.ctr[1]);
    assign bus.o_target        = lk_hit ? lk_ent.target : '0;

    always_comb begin
        upd_ent  = ent_q[upd_idx];
        upd_hit  = upd_ent.valid & (upd_ent.tag == upd_tag);
        wr_en    = 1'b0;
        wr_ent_d = upd_ent;
        if (bus.i_upd_valid) begin
            if (upd_hit) begin
                wr_en            = 1'b1;
                wr_ent_d.is_jump = bus.i_upd_is_jump;
                if (bus.i_upd_taken) begin
                    wr_ent_d.target = bus.i_upd_target;
                    if (upd_ent.ctr != 2'b11) wr_ent_d.ctr = upd_ent.ctr + 2'd1;
                end else if (upd_ent.ctr != 2'b00) begin
                    wr_ent_d.ctr = upd_ent.ctr - 2'd1;
                end
            end else if (bus.i_upd_taken) begin
                // Taken miss evicts whatever lived at this index, starting weakly taken
                wr_en    = 1'b1;
                wr_ent_d = entry_t'{valid: 1'b1, tag: upd_tag, target: bus.i_upd_target,
                                    is_jump: bus.i_upd_is_jump, ctr: 2'b10};
            end
        end
    end

    always_comb begin
        lookup_cnt_d = lookup_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        if (bus.i_lookup_valid && lookup_cnt_q != '1) lookup_cnt_d = lookup_cnt_q + 1'b1;
        if (lk_hit && hit_cnt_q != '1)                hit_cnt_d    = hit_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else begin
            if (bus.i_flush) begin
                for (int i = 0; i < ENTRIES; i++) ent_q[i].valid <= 1'b0;
            end else if (wr_en) begin
                ent_q[upd_idx] <= wr_ent_d;
            end
            lookup_cnt_q <= lookup_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
        end
    end

    assign bus.o_lookup_count = lookup_cnt_q;
    assign bus.o_hit_count    = hit_cnt_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer (ENTRIES=16: index = pc[5:2]).
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    localparam logic [31:0] PA = 32'h0040_0010;  // idx 4
    localparam logic [31:0] PJ = 32'h0040_0020;  // idx 8
    localparam logic [31:0] PL = 32'h0040_0060;  // idx 8, alias of PJ
    localparam logic [31:0] T1 = 32'h0040_0100;
    localparam logic [31:0] T2 = 32'h0040_0200;
    localparam logic [31:0] T3 = 32'h0040_0300;

    branch_target_buffer_if bus ();
    branch_target_buffer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic        hit, pt;
    logic [31:0] tgt;

    task automatic idle_inputs();
        bus.i_lookup_valid = 1'b0; bus.i_lookup_pc  = '0;
        bus.i_upd_valid    = 1'b0; bus.i_upd_pc     = '0; bus.i_upd_target = '0;
        bus.i_upd_taken    = 1'b0; bus.i_upd_is_jump = 1'b0; bus.i_flush = 1'b0;
    endtask

    // One-cycle update (optionally with flush) committed at the next rising edge
    task automatic do_upd(input logic [31:0] pc, input logic [31:0] t, input logic tk,
                          input logic jmp, input logic fl);
        @(negedge clk);
        bus.i_upd_valid = 1'b1; bus.i_upd_pc = pc; bus.i_upd_target = t;
        bus.i_upd_taken = tk; bus.i_upd_is_jump = jmp; bus.i_flush = fl;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // One-cycle lookup; outputs sampled mid-cycle, before the edge that counts it
    task automatic do_lookup(input logic [31:0] pc, output logic h, output logic p,
                             output logic [31:0] t);
        @(negedge clk);
        bus.i_lookup_valid = 1'b1; bus.i_lookup_pc = pc;
        #1;
        h = bus.o_hit; p = bus.o_predict_taken; t = bus.o_target;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.i_lookup_valid = 1'b1; bus.i_lookup_pc = PA;
        @(posedge clk); #1;
        n_chk++; if (bus.o_hit !== 1'b0) $display("FAIL rst_hit got %0b exp 0", bus.o_hit); else n_pass++;
        n_chk++; if (bus.o_predict_taken !== 1'b0) $display("FAIL rst_pt got %0b exp 0", bus.o_predict_taken); else n_pass++;
        n_chk++; if (bus.o_target !== 32'h0) $display("FAIL rst_tgt got %h exp 0", bus.o_target); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (bus.o_lookup_count !== 16'd0) $display("FAIL rst_lkcnt got %0d exp 0", bus.o_lookup_count); else n_pass++;
        n_chk++; if (bus.o_hit_count !== 16'd0) $display("FAIL rst_hitcnt got %0d exp 0", bus.o_hit_count); else n_pass++;
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_miss_lookup();
        do_lookup(PA, hit, pt, tgt);
        n_chk++; if (hit !== 1'b0) $display("FAIL miss_hit got %0b exp 0", hit); else n_pass++;
        n_chk++; if (tgt !== 32'h0) $display("FAIL miss_tgt got %h exp 0", tgt); else n_pass++;
        n_chk++; if (bus.o_lookup_count !== 16'd1) $display("FAIL miss_lkcnt got %0d exp 1", bus.o_lookup_count); else n_pass++;
        n_chk++; if (bus.o_hit_count !== 16'd0) $display("FAIL miss_hitcnt got %0d exp 0", bus.o_hit_count); else n_pass++;
    endtask

    task automatic test_alloc();
        do_upd(PA, T1, 1'b1, 1'b0, 1'b0);
        do_lookup(PA, hit, pt, tgt);
        n_chk++; if (hit !== 1'b1) $display("FAIL alloc_hit got %0b exp 1", hit); else n_pass++;
        n_chk++; if (pt !== 1'b1) $display("FAIL alloc_pt got %0b exp 1", pt); else n_pass++;
        n_chk++; if (tgt !== T1) $display("FAIL alloc_tgt got %h exp %h", tgt, T1); else n_pass++;
    endtask

    task automatic test_counter();
        // ctr 2 -> 1 -> 0; target must survive not-taken updates
        do_upd(PA, 32'h0BAD_0000, 1'b0, 1'b0, 1'b0);
        do_upd(PA, 32'h0BAD_0000, 1'b0, 1'b0, 1'b0);
        do_lookup(PA, hit, pt, tgt);
        n_chk++; if (hit !== 1'b1) $display("FAIL ctr0_hit got %0b exp 1", hit); else n_pass++;
        n_chk++; if (pt !== 1'b0) $display("FAIL ctr0_pt got %0b exp 0", pt); else n_pass++;
        n_chk++; if (tgt !== T1) $display("FAIL ctr0_tgt got %h exp %h", tgt, T1); else n_pass++;
        // saturate at 0, then two taken -> 2
        do_upd(PA, 32'h0BAD_0000, 1'b0, 1'b0, 1'b0);
        do_upd(PA, T2, 1'b1, 1'b0, 1'b0);
        do_upd(PA, T2, 1'b1, 1'b0, 1'b0);
        do_lookup(PA, hit, pt, tgt);
        n_chk++; if (pt !== 1'b1) $display("FAIL ctr_satlo_pt got %0b exp 1", pt); else n_pass++;
        n_chk++; if (tgt !== T2) $display("FAIL ctr_newtgt got %h exp %h", tgt, T2); else n_pass++;
        // 2 -> 3 -> 3 (saturate), then two not-taken -> 1
        do_upd(PA, T2, 1'b1, 1'b0, 1'b0);
        do_upd(PA, T2, 1'b1, 1'b0, 1'b0);
        do_upd(PA, T2, 1'b0, 1'b0, 1'b0);
        do_upd(PA, T2, 1'b0, 1'b0, 1'b0);
        do_lookup(PA, hit, pt, tgt);
        n_chk++; if (pt !== 1'b0) $display("FAIL ctr_sathi_pt got %0b exp 0", pt); else n_pass++;
        n_chk++; if (bus.o_lookup_count !== 16'd5) $display("FAIL ctr_lkcnt got %0d exp 5", bus.o_lookup_count); else n_pass++;
        n_chk++; if (bus.o_hit_count !== 16'd4) $display("FAIL ctr_hitcnt got %0d exp 4", bus.o_hit_count); else n_pass++;
    endtask

    task automatic test_no_alloc();
        do_upd(32'h0040_0030, T3, 1'b0, 1'b0, 1'b0);
        do_lookup(32'h0040_0030, hit, pt, tgt);
        n_chk++; if (hit !== 1'b0) $display("FAIL noalloc_hit got %0b exp 0", hit); else n_pass++;
    endtask

    task automatic test_jump_alias();
        do_upd(PJ, 32'h0040_1000, 1'b1, 1'b1, 1'b0);
        do_lookup(PJ, hit, pt, tgt);
        n_chk++; if (hit !== 1'b1 || pt !== 1'b1) $display("FAIL jmp_hit got hit=%0b pt=%0b exp 1/1", hit, pt); else n_pass++;
        n_chk++; if (tgt !== 32'h0040_1000) $display("FAIL jmp_tgt got %h exp 00401000", tgt); else n_pass++;
        // ctr drops to 1 but is_jump still forces taken
        do_upd(PJ, 32'h0, 1'b0, 1'b1, 1'b0);
        do_lookup(PJ, hit, pt, tgt);
        n_chk++; if (pt !== 1'b1) $display("FAIL jmp_force_pt got %0b exp 1", pt); else n_pass++;
        do_upd(PL, 32'h0040_2000, 1'b1, 1'b0, 1'b0);
        do_lookup(PJ, hit, pt, tgt);
        n_chk++; if (hit !== 1'b0 || tgt !== 32'h0) $display("FAIL alias_old got hit=%0b tgt=%h exp 0/0", hit, tgt); else n_pass++;
        do_lookup(PL, hit, pt, tgt);
        n_chk++; if (hit !== 1'b1 || pt !== 1'b1) $display("FAIL alias_new got hit=%0b pt=%0b exp 1/1", hit, pt); else n_pass++;
        n_chk++; if (tgt !== 32'h0040_2000) $display("FAIL alias_tgt got %h exp 00402000", tgt); else n_pass++;
        do_lookup(PL | 32'h3, hit, pt, tgt);
        n_chk++; if (hit !== 1'b1) $display("FAIL pc_lsb_hit got %0b exp 1", hit); else n_pass++;
    endtask

    task automatic test_back_to_back();
        // PA holds ctr=1, target T2; same-cycle taken update to T3
        @(negedge clk);
        bus.i_lookup_valid = 1'b1; bus.i_lookup_pc = PA;
        bus.i_upd_valid = 1'b1; bus.i_upd_pc = PA; bus.i_upd_target = T3;
        bus.i_upd_taken = 1'b1; bus.i_upd_is_jump = 1'b0;
        #1;
        hit = bus.o_hit; pt = bus.o_predict_taken; tgt = bus.o_target;
        @(posedge clk); #1;
        idle_inputs();
        n_chk++; if (hit !== 1'b1 || pt !== 1'b0) $display("FAIL b2b_old got hit=%0b pt=%0b exp 1/0", hit, pt); else n_pass++;
        n_chk++; if (tgt !== T2) $display("FAIL b2b_oldtgt got %h exp %h", tgt, T2); else n_pass++;
        do_lookup(PA, hit, pt, tgt);
        n_chk++; if (pt !== 1'b1 || tgt !== T3) $display("FAIL b2b_new got pt=%0b tgt=%h exp 1/%h", pt, tgt, T3); else n_pass++;
    endtask

    task automatic test_flush();
        do_upd(32'h0040_0040, 32'h0040_3000, 1'b1, 1'b0, 1'b1);
        do_lookup(PA, hit, pt, tgt);
        n_chk++; if (hit !== 1'b0) $display("FAIL flush_a got %0b exp 0", hit); else n_pass++;
        do_lookup(PL, hit, pt, tgt);
        n_chk++; if (hit !== 1'b0) $display("FAIL flush_l got %0b exp 0", hit); else n_pass++;
        do_lookup(32'h0040_0040, hit, pt, tgt);
        n_chk++; if (hit !== 1'b0 || tgt !== 32'h0) $display("FAIL flush_upd got hit=%0b tgt=%h exp 0/0", hit, tgt); else n_pass++;
        n_chk++; if (bus.o_lookup_count !== 16'd16) $display("FAIL flush_lkcnt got %0d exp 16", bus.o_lookup_count); else n_pass++;
        n_chk++; if (bus.o_hit_count !== 16'd10) $display("FAIL flush_hitcnt got %0d exp 10", bus.o_hit_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_upd(PA, T1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_lookup_valid = 1'b1; bus.i_lookup_pc = PA;
        bus.i_upd_valid = 1'b1; bus.i_upd_pc = 32'h0040_0070; bus.i_upd_target = T3;
        bus.i_upd_taken = 1'b1;
        #1;
        n_chk++; if (bus.o_hit !== 1'b0 || bus.o_target !== 32'h0) $display("FAIL rstmid_out got hit=%0b tgt=%h exp 0/0", bus.o_hit, bus.o_target); else n_pass++;
        n_chk++; if (bus.o_lookup_count !== 16'd0 || bus.o_hit_count !== 16'd0) $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", bus.o_lookup_count, bus.o_hit_count); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        // first edge after release must accept an update
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_upd_valid = 1'b1; bus.i_upd_pc = 32'h0040_0050; bus.i_upd_target = 32'h0040_4000;
        bus.i_upd_taken = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        do_lookup(32'h0040_0070, hit, pt, tgt);
        n_chk++; if (hit !== 1'b0) $display("FAIL rstmid_discard got %0b exp 0", hit); else n_pass++;
        do_lookup(32'h0040_0050, hit, pt, tgt);
        n_chk++; if (hit !== 1'b1 || tgt !== 32'h0040_4000) $display("FAIL rst_first_upd got hit=%0b tgt=%h exp 1/00404000", hit, tgt); else n_pass++;
        n_chk++; if (bus.o_lookup_count !== 16'd2 || bus.o_hit_count !== 16'd1) $display("FAIL rst_cnt got %0d/%0d exp 2/1", bus.o_lookup_count, bus.o_hit_count); else n_pass++;
    endtask

    task automatic test_cnt_sat();
        @(negedge clk);
        bus.i_lookup_valid = 1'b1; bus.i_lookup_pc = 32'h0040_0050;
        repeat (65536 + 5) @(posedge clk);
        #1;
        n_chk++; if (bus.o_lookup_count !== 16'hFFFF) $display("FAIL sat_lkcnt got %h exp ffff", bus.o_lookup_count); else n_pass++;
        n_chk++; if (bus.o_hit_count !== 16'hFFFF) $display("FAIL sat_hitcnt got %h exp ffff", bus.o_hit_count); else n_pass++;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_miss_lookup();
        test_alloc();
        test_counter();
        test_no_alloc();
        test_jump_alias();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_cnt_sat();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
